// File: rtl/muldiv_ctrl_pkg.sv
// Shared types, op codes and helpers for the multiply/divide sequencer.
// Op codes 4..7 (multiply-accumulate) are only legal when MULACC_EN is defined.
package muldiv_ctrl_pkg;

  localparam int REG_W     = 32;
  localparam int DIV_ITERS = REG_W;
  localparam int CNT_W     = $clog2(DIV_ITERS);

  typedef logic [REG_W-1:0] word_t;
  typedef logic [3:0]       md_op_t;

  localparam md_op_t MD_MULT  = 4'd0;
  localparam md_op_t MD_MULTU = 4'd1;
  localparam md_op_t MD_DIV   = 4'd2;
  localparam md_op_t MD_DIVU  = 4'd3;
  localparam md_op_t MD_MADD  = 4'd4;
  localparam md_op_t MD_MADDU = 4'd5;
  localparam md_op_t MD_MSUB  = 4'd6;
  localparam md_op_t MD_MSUBU = 4'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } md_state_e;

  function automatic logic md_valid(input md_op_t op);
`ifdef MULACC_EN
    return op <= MD_MSUBU;
`else
    return op <= MD_DIVU;
`endif
  endfunction

  function automatic logic md_is_div(input md_op_t op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic md_is_signed(input md_op_t op);
    return (op == MD_MULT) || (op == MD_DIV) || (op == MD_MADD) || (op == MD_MSUB);
  endfunction

  function automatic word_t abs_if(input logic en, input word_t v);
    return (en && v[REG_W-1]) ? -v : v;
  endfunction

endpackage

// File: rtl/muldiv_ctrl_if.sv
// EX-stage <-> mul/div sequencer signal bundle; slave is the sequencer side.
interface muldiv_ctrl_if;
  import muldiv_ctrl_pkg::*;

  logic   start_i;
  md_op_t op_i;
  word_t  src1_i;
  word_t  src2_i;
  logic   flush_i;
  word_t  hi_i;
  word_t  lo_i;
  logic   stall_o;
  logic   hilo_we_o;
  word_t  hi_o;
  word_t  lo_o;

  modport slave (
    input  start_i, op_i, src1_i, src2_i, flush_i, hi_i, lo_i,
    output stall_o, hilo_we_o, hi_o, lo_o
  );

  modport master (
    output start_i, op_i, src1_i, src2_i, flush_i, hi_i, lo_i,
    input  stall_o, hilo_we_o, hi_o, lo_o
  );
endinterface

// File: rtl/muldiv_div_core.sv
// One restoring-division step: shift {rem,quot} left by one, subtract divisor if it fits.
module muldiv_div_core
  import muldiv_ctrl_pkg::*;
(
  input  word_t rem_i,
  input  word_t quot_i,
  input  word_t divisor_i,
  output word_t rem_o,
  output word_t quot_o
);

  logic [REG_W:0] shifted;

  // NOTE: every output of a combinational block gets a value on every path, otherwise a latch is inferred.
  always_comb begin
    shifted = {rem_i, quot_i[REG_W-1]};
    rem_o   = shifted[REG_W-1:0];
    quot_o  = {quot_i[REG_W-2:0], 1'b0};
    if (shifted >= {1'b0, divisor_i}) begin
      rem_o  = REG_W'(shifted - {1'b0, divisor_i});
      quot_o = {quot_i[REG_W-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/muldiv_ctrl.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer feeding a one-cycle HI/LO write.
// Define MULACC_EN to add MADD/MADDU/MSUB/MSUBU accumulating into hi_i/lo_i.
module muldiv_ctrl
  import muldiv_ctrl_pkg::*;
(
  input  logic cpu_clk_50M,
  input  logic cpu_rst_n,
  muldiv_ctrl_if.slave md
);

  md_state_e        state_q, state_d;
  md_op_t           op_q;
  word_t            a_q, b_q, rem_q;
  word_t            hi_q, lo_q;
  logic [CNT_W-1:0] count_q;
  logic             q_neg_q, r_neg_q;

  logic             accept, stall_d, in_signed, div_by_zero, last_iter;
  word_t            rem_n, quot_n;
  logic [2*REG_W-1:0] ext_a, ext_b, prod, mul_res;

  assign accept      = md.start_i & md_valid(md.op_i) & ~md.flush_i;
  assign in_signed   = md_is_signed(md.op_i);
  assign div_by_zero = md_is_div(md.op_i) & (md.src2_i == '0);
  assign last_iter   = (count_q == CNT_W'(DIV_ITERS - 1));

  // Sign/zero extension lets one 64-bit multiplier serve both signed and unsigned ops.
  assign ext_a = {{REG_W{md_is_signed(op_q) & a_q[REG_W-1]}}, a_q};
  assign ext_b = {{REG_W{md_is_signed(op_q) & b_q[REG_W-1]}}, b_q};
  assign prod  = ext_a * ext_b;

`ifdef MULACC_EN
  always_comb begin
    mul_res = prod;
    case (op_q)
      MD_MADD, MD_MADDU: mul_res = {md.hi_i, md.lo_i} + prod;
      MD_MSUB, MD_MSUBU: mul_res = {md.hi_i, md.lo_i} - prod;
      default:           mul_res = prod;
    endcase
  end
`else
  logic unused_hilo;
  assign unused_hilo = ^{md.hi_i, md.lo_i};
  assign mul_res     = prod;
`endif

  muldiv_div_core u_div_core (
    .rem_i     (rem_q),
    .quot_i    (a_q),
    .divisor_i (b_q),
    .rem_o     (rem_n),
    .quot_o    (quot_n)
  );

  always_comb begin
    state_d = state_q;
    stall_d = 1'b0;
    case (state_q)
      ST_IDLE: if (accept) begin
        stall_d = 1'b1;
        if (div_by_zero)               state_d = ST_DONE;
        else if (md_is_div(md.op_i))   state_d = ST_DIV;
        else                           state_d = ST_MUL;
      end
      ST_MUL: begin
        stall_d = 1'b1;
        state_d = ST_DONE;
      end
      ST_DIV: begin
        stall_d = 1'b1;
        if (last_iter) state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (md.flush_i) begin
      state_d = ST_IDLE;
      stall_d = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments; reset is synchronous, sampled on the clock edge.
  always_ff @(posedge cpu_clk_50M) begin
    if (!cpu_rst_n) begin
      state_q <= ST_IDLE;
      op_q    <= MD_MULT;
      a_q     <= '0;
      b_q     <= '0;
      rem_q   <= '0;
      count_q <= '0;
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        ST_IDLE: if (accept) begin
          op_q    <= md.op_i;
          count_q <= '0;
          rem_q   <= '0;
          q_neg_q <= in_signed & (md.src1_i[REG_W-1] ^ md.src2_i[REG_W-1]);
          r_neg_q <= in_signed & md.src1_i[REG_W-1];
          if (md_is_div(md.op_i)) begin
            a_q <= abs_if(in_signed, md.src1_i);
            b_q <= abs_if(in_signed, md.src2_i);
          end else begin
            a_q <= md.src1_i;
            b_q <= md.src2_i;
          end
          if (div_by_zero) begin
            hi_q <= md.src1_i;
            lo_q <= '1;
          end
        end
        ST_MUL: if (!md.flush_i) {hi_q, lo_q} <= mul_res;
        ST_DIV: begin
          if (md.flush_i) begin
            count_q <= '0;
          end else begin
            a_q     <= quot_n;
            rem_q   <= rem_n;
            count_q <= count_q + 1'b1;
            if (last_iter) begin
              lo_q <= q_neg_q ? -quot_n : quot_n;
              hi_q <= r_neg_q ? -rem_n : rem_n;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign md.stall_o   = cpu_rst_n & stall_d;
  assign md.hilo_we_o = cpu_rst_n & ~md.flush_i & (state_q == ST_DONE);
  assign md.hi_o      = hi_q;
  assign md.lo_o      = lo_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl: directed cases plus random ops against an arithmetic model.
module tb_muldiv_ctrl;
  import muldiv_ctrl_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  muldiv_ctrl_if md();

  muldiv_ctrl dut (
    .cpu_clk_50M (clk),
    .cpu_rst_n   (rst_n),
    .md          (md)
  );

  int n_vec = 0;
  int n_bad = 0;
  logic [31:0] hi_reg = '0;
  logic [31:0] lo_reg = '0;

`ifdef MULACC_EN
  localparam int MAX_OP = 7;
`else
  localparam int MAX_OP = 3;
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference result {hi,lo} from plain arithmetic on the architectural operands.
  function automatic logic [63:0] ref_result(input logic [3:0] op, input logic [31:0] a,
                                             input logic [31:0] b, input logic [31:0] hi,
                                             input logic [31:0] lo);
    longint sa, sb, q, r;
    logic [63:0] up, sp;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    up = {32'b0, a} * {32'b0, b};
    sp = 64'(sa * sb);
    case (op)
      4'd0: return sp;
      4'd1: return up;
      4'd2: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      4'd3: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
      4'd4: return {hi, lo} + sp;
      4'd5: return {hi, lo} + up;
      4'd6: return {hi, lo} - sp;
      default: return {hi, lo} - up;
    endcase
  endfunction

  function automatic int ref_latency(input logic [3:0] op, input logic [31:0] b);
    if (op == 4'd2 || op == 4'd3) return (b == 0) ? 1 : 33;
    return 2;
  endfunction

  task automatic drive(input logic s, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic f);
    md.start_i = s;
    md.op_i    = op;
    md.src1_i  = a;
    md.src2_i  = b;
    md.flush_i = f;
    md.hi_i    = hi_reg;
    md.lo_i    = lo_reg;
  endtask

  task automatic check_idle(input string tag);
    check({tag, " stall"}, 32'(md.stall_o), 32'd0);
    check({tag, " we"},    32'(md.hilo_we_o), 32'd0);
    check({tag, " hi"},    md.hi_o, hi_reg);
    check({tag, " lo"},    md.lo_o, lo_reg);
  endtask

  // Runs one op from its start cycle; flush_at < 0 means no flush.
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int flush_at);
    logic [63:0] r;
    int lat, tail;
    string tag;
    r    = ref_result(op, a, b, hi_reg, lo_reg);
    lat  = ref_latency(op, b);
    tail = (flush_at >= 0) ? (lat - flush_at + 2) : 1;
    for (int k = 0; k <= lat; k++) begin
      @(negedge clk);
      drive(1'b1, op, a, b, k == flush_at);
      #1;
      tag = $sformatf("op%0d a=%h b=%h k=%0d", op, a, b, k);
      if (k == flush_at) begin
        check_idle({tag, " flush"});
        break;
      end
      check({tag, " stall"}, 32'(md.stall_o), 32'(k < lat));
      check({tag, " we"},    32'(md.hilo_we_o), 32'(k == lat));
      if (k == lat) begin
        check({tag, " hi"}, md.hi_o, r[63:32]);
        check({tag, " lo"}, md.lo_o, r[31:0]);
        hi_reg = r[63:32];
        lo_reg = r[31:0];
      end else begin
        check({tag, " hi held"}, md.hi_o, hi_reg);
        check({tag, " lo held"}, md.lo_o, lo_reg);
      end
    end
    for (int t = 0; t < tail; t++) begin
      @(negedge clk);
      drive(1'b0, MD_MULT, '0, '0, 1'b0);
      #1;
      check_idle($sformatf("op%0d after t=%0d", op, t));
    end
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(1, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [3:0] rop;
    logic [31:0] ra, rb;

    // Reset: start held high, stall and write must stay low.
    drive(1'b1, MD_DIV, 32'd7, 32'd2, 1'b0);
    @(negedge clk);
    #1;
    check("reset stall", 32'(md.stall_o), 32'd0);
    check("reset we", 32'(md.hilo_we_o), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b0, MD_MULT, '0, '0, 1'b0);
    #1;
    check_idle("post-reset");

    run_op(MD_MULT,  32'hFFFF_FFFE, 32'd3, -1);
    run_op(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1);
    run_op(MD_DIV,   32'hFFFF_FFF9, 32'd2, -1);

    // Reset in the middle of a divide: no write, outputs cleared.
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      drive(1'b1, MD_DIVU, 32'd1000, 32'd3, 1'b0);
      #1;
      check($sformatf("rst-mid stall k=%0d", k), 32'(md.stall_o), 32'd1);
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst-mid stall in reset", 32'(md.stall_o), 32'd0);
    check("rst-mid we in reset", 32'(md.hilo_we_o), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b0, MD_MULT, '0, '0, 1'b0);
    hi_reg = '0;
    lo_reg = '0;
    for (int t = 0; t < 35; t++) begin
      @(negedge clk);
      #1;
      check_idle($sformatf("rst-mid after t=%0d", t));
    end

    run_op(MD_DIVU, 32'd100, 32'd0, -1);
    run_op(MD_DIVU, 32'd100, 32'd7, 10);

    // Flush and start together in IDLE: nothing starts.
    @(negedge clk);
    drive(1'b1, MD_MULT, 32'd5, 32'd6, 1'b1);
    #1;
    check_idle("flush+start");
    for (int t = 0; t < 4; t++) begin
      @(negedge clk);
      drive(1'b0, MD_MULT, '0, '0, 1'b0);
      #1;
      check_idle($sformatf("flush+start after t=%0d", t));
    end

    // Undefined op codes never stall or write.
    for (int t = 0; t < 4; t++) begin
      @(negedge clk);
`ifdef MULACC_EN
      drive(1'b1, (t < 2) ? 4'd9 : 4'd15, 32'd3, 32'd4, 1'b0);
`else
      drive(1'b1, (t < 2) ? 4'd4 : 4'd15, 32'd3, 32'd4, 1'b0);
`endif
      #1;
      check_idle($sformatf("undef op t=%0d", t));
    end

`ifdef MULACC_EN
    run_op(MD_MULTU, 32'd5, 32'd1, -1);
    run_op(MD_MADD,  32'd3, 32'd4, -1);
    check("madd lo", md.lo_o, 32'd17);
    run_op(MD_MSUBU, 32'd2, 32'd1, -1);
    check("msubu lo", md.lo_o, 32'd15);
`endif

    for (int i = 0; i < 40; i++) begin
      rop = 4'($urandom_range(0, MAX_OP));
      ra  = pick_operand();
      rb  = pick_operand();
      run_op(rop, ra, rb, -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
